pcie_bram_table_arb: RTL and testbench
======================================

# pcie_bram_table_arb

Shared, parametrised BRAM table with NUM_CH requester channels, fixed-latency reads and round-robin arbitration. It sits in the PCIe block and replaces the fixed 32-bit, single-user table port with configurable data/address width. Several engines (descriptor, packet-queue and config paths) share one single-port table without external muxing, and read data is routed back to the issuing channel.

## Interface
Parameters:
- DATA_WIDTH, 32, table entry width in bits
- ADDR_WIDTH, BRAM_TABLE_IDX_WIDTH, index width; depth = 2**ADDR_WIDTH
- NUM_CH, 4, requester channels (≥1)

Ports (clock and reset are listed first):
- clk  in  1  sole clock
- rst_n  in  1  asynchronous, active-low reset
- ch_addr  in  NUM_CH*ADDR_WIDTH  per-channel index; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- ch_wr_data  in  NUM_CH*DATA_WIDTH  per-channel write data
- ch_rd_en  in  NUM_CH  read request
- ch_wr_en  in  NUM_CH  write request
- ch_ready  out  NUM_CH  grant, one-hot or zero; a request is accepted when it is pending and ready is high
- rd_data  out  DATA_WIDTH  read data, broadcast to all channels
- rd_valid  out  NUM_CH  one-hot; qualifies rd_data for the issuing channel
- init_done  out  1  table usable; no grants are issued while it is low

Reset values: ch_ready=0, rd_valid=0, rd_data=0. init_done=1, or 0 with BRAM_INIT_CLEAR_EN. Table contents are not reset.

## Operation
- Channel i requests when ch_rd_en[i] | ch_wr_en[i]. The requester holds addr, data and enables stable until granted.
- Arbitration is round-robin and combinational. The first requesting channel at or after rr_ptr wins. rr_ptr resets to 0 and becomes (winner+1) mod NUM_CH on each grant. The pointer is unchanged when there is no grant.
- At most one grant is issued per cycle. A lone requester is granted every cycle (full throughput).
- Write (wr_en only): mem[addr] ← wr_data at the clock edge closing the grant cycle.
- Read (rd_en only): returns mem[addr].
- rd_en and wr_en together: read-first. rd_data returns the old contents and the write commits.
- Read routing: the granted channel index and read flag travel down a 2-stage valid pipeline alongside the memory read.
- Address, data and enables from non-granted channels are ignored.
- Reset mid-operation clears the pipeline. In-flight reads never produce rd_valid. rr_ptr returns to 0. Table contents are undefined unless the clear sweep runs.

## Timing
- A read accepted in cycle t gives rd_valid[ch] high with rd_data in cycle t+2 only. The path is a registered BRAM output plus an output register.
- A write accepted in cycle t is visible to a read accepted in cycle t+1 or later. There is no forwarding requirement.
- Back-to-back reads from different channels give back-to-back rd_valid in grant order.
- ch_ready depends combinationally on the current ch_rd_en/ch_wr_en and on registered rr_ptr/init_done. There is no path from rd_data.
- rd_data holds its last value when rd_valid=0.

## Configuration
- BRAM_INIT_CLEAR_EN defined:
  - After rst_n deassertion, an internal counter writes 0 to every entry, 0 … 2**ADDR_WIDTH−1, one per cycle.
  - init_done goes high in the cycle after the final write. Total time is 2**ADDR_WIDTH cycles, then init_done.
  - ch_ready stays 0 throughout.
  - Reasserting rst_n mid-sweep restarts the sweep from 0.
- BRAM_INIT_CLEAR_EN undefined: there is no sweep and init_done is constant 1 after reset.

## Test plan
- Single channel: write 0xDEADBEEF to index 5 in cycle t, then read index 5 in t+1 -> rd_valid[0] in t+3 with rd_data=0xDEADBEEF.
- Contention: channels 0, 1 and 3 all request reads in the same cycle and hold until granted -> grants in order 0, 1, 3 on consecutive cycles, and rd_valid one-hot in the same order two cycles later. A fresh request from 0 right after is granted after 3.
- Read-first: entry 7=0x11. Assert rd_en+wr_en with data 0x22 on channel 2 -> rd_data=0x11 at +2. A subsequent read returns 0x22.
- Streaming: channel 1 issues reads to indices 0..15 every cycle -> ch_ready held 1, 16 consecutive rd_valid[1] pulses in order.
- Reset mid-read: assert rst_n=0 one cycle after a read grant -> rd_valid stays 0, ch_ready=0 during reset, rr_ptr=0 afterwards.
- With BRAM_INIT_CLEAR_EN and ADDR_WIDTH=4: after reset, init_done=0 for 16 cycles and no grants while requests are pending. Then init_done=1 and a read of every index returns 0.

Source files
------------

// File: rtl/pcie_bram_table_arb.sv
// pcie_bram_table_arb: single-port BRAM table shared by NUM_CH requesters.
// Round-robin combinational arbitration, read-first access, fixed 2-cycle
// read latency with the read data routed back to the issuing channel.
// Optional feature macro: BRAM_INIT_CLEAR_EN (zero-sweep of the table after
// reset, with init_done held low until the sweep completes).
`ifndef BRAM_TABLE_IDX_WIDTH
`define BRAM_TABLE_IDX_WIDTH 10
`endif
module pcie_bram_table_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = `BRAM_TABLE_IDX_WIDTH,
    parameter int NUM_CH     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wr_data,
    input  logic [NUM_CH-1:0]            ch_rd_en,
    input  logic [NUM_CH-1:0]            ch_wr_en,
    output logic [NUM_CH-1:0]            ch_ready,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic [NUM_CH-1:0]            rd_valid,
    output logic                         init_done
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0]      rr_ptr;
    logic [NUM_CH-1:0]     req;
    logic [NUM_CH-1:0]     gnt_oh;
    logic [PTR_W-1:0]      gnt_idx;
    logic                  gnt_vld;
    logic                  gnt_rd;
    logic                  gnt_wr;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_wdata;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic [DATA_WIDTH-1:0] rdata_p1;
    logic                  vld_p1;
    logic [PTR_W-1:0]      ch_p1;

    assign req      = ch_rd_en | ch_wr_en;
    assign ch_ready = gnt_oh;

    // Round-robin search from rr_ptr; no grant while in reset or before init completes
    always_comb begin
        int   idx;
        logic found;
        found   = 1'b0;
        idx     = 0;
        gnt_idx = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = PTR_W'(idx);
            end
        end
        gnt_vld = found && init_done && rst_n;
    end

    // Select the winning channel's address, data and enables
    always_comb begin
        gnt_oh    = '0;
        gnt_rd    = 1'b0;
        gnt_wr    = 1'b0;
        gnt_addr  = '0;
        gnt_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_vld && (gnt_idx == PTR_W'(i))) begin
                gnt_oh[i] = 1'b1;
                gnt_rd    = ch_rd_en[i];
                gnt_wr    = ch_wr_en[i];
                gnt_addr  = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                gnt_wdata = ch_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Move the pointer one past each winner; hold it when nothing is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (gnt_vld) begin
            rr_ptr <= (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

`ifdef BRAM_INIT_CLEAR_EN
    logic [ADDR_WIDTH-1:0] clr_cnt;

    // Zero one entry per cycle after reset; init_done rises after the last entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else if (!init_done) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == {ADDR_WIDTH{1'b1}}) init_done <= 1'b1;
        end
    end

    assign mem_we    = gnt_wr | (!init_done && rst_n);
    assign mem_waddr = init_done ? gnt_addr : clr_cnt;
    assign mem_wdata = init_done ? gnt_wdata : '0;
`else
    assign init_done = 1'b1;
    assign mem_we    = gnt_wr;
    assign mem_waddr = gnt_addr;
    assign mem_wdata = gnt_wdata;
`endif

    // Table port: read-first, the registered read captures pre-write contents
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (gnt_rd) rdata_p1 <= mem[gnt_addr];
    end

    // Stage p1: carry read flag and issuing channel alongside the BRAM output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            ch_p1  <= '0;
        end else begin
            vld_p1 <= gnt_rd;
            ch_p1  <= gnt_idx;
        end
    end

    // Stage p2: output register, rd_data holds its value between valid reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                rd_valid[i] <= vld_p1 && (ch_p1 == PTR_W'(i));
            end
            if (vld_p1) rd_data <= rdata_p1;
        end
    end
endmodule

// File: tb/tb_pcie_bram_table_arb.sv
// Testbench for pcie_bram_table_arb: table-driven single-channel vectors plus
// hand-written multi-cycle sequences (contention, streaming, reset, init sweep).
module tb_pcie_bram_table_arb;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NC = 4;
`ifdef BRAM_INIT_CLEAR_EN
    localparam logic EXP_INIT_RST = 1'b0;
`else
    localparam logic EXP_INIT_RST = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [NC*AW-1:0] ch_addr = '0;
    logic [NC*DW-1:0] ch_wr_data = '0;
    logic [NC-1:0] ch_rd_en = '0;
    logic [NC-1:0] ch_wr_en = '0;
    logic [NC-1:0] ch_ready;
    logic [DW-1:0] rd_data;
    logic [NC-1:0] rd_valid;
    logic          init_done;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        int            ch;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vt [11];

    always #5 clk = ~clk;

    pcie_bram_table_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC)) dut (
        .clk(clk), .rst_n(rst_n), .ch_addr(ch_addr), .ch_wr_data(ch_wr_data),
        .ch_rd_en(ch_rd_en), .ch_wr_en(ch_wr_en), .ch_ready(ch_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .init_done(init_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] oh(input int ch);
        return 64'd1 << ch;
    endfunction

    task automatic set_req(input int ch, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        ch_rd_en[ch] = rd;
        ch_wr_en[ch] = wr;
        ch_addr[ch*AW +: AW] = a;
        ch_wr_data[ch*DW +: DW] = d;
    endtask

    task automatic clear_req();
        ch_rd_en = '0;
        ch_wr_en = '0;
    endtask

    task automatic wait_init();
        for (int i = 0; i < 64 && !init_done; i++) @(negedge clk);
        #1 check("wait_init_done", init_done, 1);
    endtask

    // Stream reads of indices 0..15 on one channel; expected = base | (use_idx ? idx : 0)
    task automatic stream_read(input int ch, input logic [DW-1:0] base, input logic use_idx);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (k < 16) set_req(ch, 1'b1, 1'b0, AW'(k), '0);
            else clear_req();
            #1;
            if (k < 16) check($sformatf("stream ready k=%0d", k), ch_ready, oh(ch));
            if (k >= 2) begin
                check($sformatf("stream valid k=%0d", k), rd_valid, oh(ch));
                check($sformatf("stream data k=%0d", k), rd_data,
                      base | (use_idx ? DW'(k - 2) : '0));
            end else begin
                check($sformatf("stream idle valid k=%0d", k), rd_valid, 0);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{0, 1'b0, 1'b1, 4'd5,  32'hDEADBEEF, 32'h0};
        vt[1]  = '{0, 1'b1, 1'b0, 4'd5,  32'h0,        32'hDEADBEEF};
        vt[2]  = '{1, 1'b0, 1'b1, 4'd3,  32'h12345678, 32'h0};
        vt[3]  = '{2, 1'b1, 1'b0, 4'd3,  32'h0,        32'h12345678};
        vt[4]  = '{3, 1'b0, 1'b1, 4'd15, 32'hFFFFFFFF, 32'h0};
        vt[5]  = '{3, 1'b1, 1'b0, 4'd15, 32'h0,        32'hFFFFFFFF};
        vt[6]  = '{1, 1'b0, 1'b1, 4'd0,  32'h00000000, 32'h0};
        vt[7]  = '{0, 1'b1, 1'b0, 4'd0,  32'h0,        32'h00000000};
        vt[8]  = '{2, 1'b0, 1'b1, 4'd7,  32'h00000011, 32'h0};
        vt[9]  = '{2, 1'b1, 1'b1, 4'd7,  32'h00000022, 32'h00000011};
        vt[10] = '{1, 1'b1, 1'b0, 4'd7,  32'h0,        32'h00000022};

        // Reset state with a request pending
        #1 rst_n = 1'b0;
        set_req(0, 1'b1, 1'b0, 4'd3, '0);
        @(negedge clk); @(negedge clk); #1;
        check("rst ch_ready", ch_ready, 0);
        check("rst rd_valid", rd_valid, 0);
        check("rst rd_data", rd_data, 0);
        check("rst init_done", init_done, EXP_INIT_RST);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef BRAM_INIT_CLEAR_EN
        for (int k = 0; k < 16; k++) begin
            #1;
            check($sformatf("sweep init_done c%0d", k), init_done, 0);
            check($sformatf("sweep ready c%0d", k), ch_ready, 0);
            @(negedge clk);
        end
        #1;
        check("sweep done init_done", init_done, 1);
        check("sweep done ready", ch_ready, oh(0));
        clear_req();
        stream_read(0, '0, 1'b0);
`else
        clear_req();
        #1 check("post-rst init_done", init_done, 1);
`endif

        // Table-driven single-channel vectors
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            set_req(vt[i].ch, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].data);
            #1 check($sformatf("vec%0d ready", i), ch_ready, oh(vt[i].ch));
            @(negedge clk);
            clear_req();
            #1 check($sformatf("vec%0d valid t+1", i), rd_valid, 0);
            @(negedge clk);
            #1;
            if (vt[i].rd) begin
                check($sformatf("vec%0d valid t+2", i), rd_valid, oh(vt[i].ch));
                check($sformatf("vec%0d data", i), rd_data, vt[i].exp);
            end else begin
                check($sformatf("vec%0d no valid", i), rd_valid, 0);
            end
        end

        // Write at t, read same index at t+1, data at t+3
        @(negedge clk);
        set_req(0, 1'b0, 1'b1, 4'd9, 32'hDEADBEEF);
        #1 check("wr_rd ready0", ch_ready, oh(0));
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 4'd9, '0);
        #1 check("wr_rd ready1", ch_ready, oh(0));
        check("wr_rd valid1", rd_valid, 0);
        @(negedge clk);
        clear_req();
        #1 check("wr_rd valid2", rd_valid, 0);
        @(negedge clk);
        #1 check("wr_rd valid3", rd_valid, oh(0));
        check("wr_rd data3", rd_data, 32'hDEADBEEF);

        // Streaming: channel 1 fills then reads 0..15 back-to-back
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            set_req(1, 1'b0, 1'b1, AW'(k), 32'hC0DE0000 | DW'(k));
            #1 check($sformatf("fill ready k=%0d", k), ch_ready, oh(1));
        end
        @(negedge clk);
        clear_req();
        stream_read(1, 32'hC0DE0000, 1'b1);

        // Reset one cycle after a read grant
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 4'd3, '0);
        #1 check("rstmid grant", ch_ready, oh(1));
        @(negedge clk);
        clear_req();
        rst_n = 1'b0;
        set_req(2, 1'b1, 1'b0, 4'd3, '0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("rstmid ready c%0d", k), ch_ready, 0);
            check($sformatf("rstmid valid c%0d", k), rd_valid, 0);
            check($sformatf("rstmid data c%0d", k), rd_data, 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        clear_req();
        #1 check("rstmid valid after", rd_valid, 0);
        @(negedge clk);
        #1 check("rstmid valid after2", rd_valid, 0);
        wait_init();

        // rr_ptr back at 0: channel 1 must beat channel 2
        @(negedge clk);
        set_req(1, 1'b0, 1'b1, 4'd10, 32'h1);
        set_req(2, 1'b0, 1'b1, 4'd11, 32'h2);
        #1 check("rrptr first", ch_ready, oh(1));
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 4'd10, 32'h1);
        #1 check("rrptr second", ch_ready, oh(2));
        @(negedge clk);
        clear_req();

        // Preload via channel 3 (pointer wraps to 0 after each grant)
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_req(3, 1'b0, 1'b1, (k == 2) ? 4'd4 : AW'(k + 1),
                    (k == 2) ? 32'h11110004 : (32'h11110000 | DW'(k + 1)));
            #1 check($sformatf("preload ready k=%0d", k), ch_ready, oh(3));
        end
        @(negedge clk);
        clear_req();

        // Contention: channels 0, 1, 3 together, then a fresh request from 0
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 4'd1, '0);
        set_req(1, 1'b1, 1'b0, 4'd2, '0);
        set_req(3, 1'b1, 1'b0, 4'd4, '0);
        #1 check("cont g0", ch_ready, oh(0));
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 4'd1, '0);
        #1 check("cont g1", ch_ready, oh(1));
        check("cont v1", rd_valid, 0);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 4'd2, '0);
        set_req(0, 1'b1, 1'b0, 4'd2, '0);
        #1 check("cont g3", ch_ready, oh(3));
        check("cont v0", rd_valid, oh(0));
        check("cont d0", rd_data, 32'h11110001);
        @(negedge clk);
        set_req(3, 1'b0, 1'b0, 4'd4, '0);
        #1 check("cont g0 fresh", ch_ready, oh(0));
        check("cont v1b", rd_valid, oh(1));
        check("cont d1", rd_data, 32'h11110002);
        @(negedge clk);
        clear_req();
        #1 check("cont idle", ch_ready, 0);
        check("cont v3", rd_valid, oh(3));
        check("cont d3", rd_data, 32'h11110004);
        @(negedge clk);
        #1 check("cont v0 fresh", rd_valid, oh(0));
        check("cont d0 fresh", rd_data, 32'h11110002);
        @(negedge clk);
        #1 check("cont v none", rd_valid, 0);
        check("cont d hold", rd_data, 32'h11110002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
